// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl: sequences the UART loader/dumper against the CPU memories.
//   clk, rst_n            : clock, async active-low reset
//   start_load/start_dump : one-cycle command pulses
//   cpu_halt              : CPU finished (level)
//   uart_*                : UART control out, address/strobe/data/done in
//   cpu_rst_n             : CPU reset, released only in RUN
//   im_*/dm_*             : registered memory write ports
//   dm_sel_uart           : DM read port mux select (1 = UART address)
//   state_o               : current state encoding
module uart_boot_ctrl #(
  parameter int unsigned IM_SIZE_BIT  = 8,
  parameter int unsigned DM_SIZE_BIT  = 8,
  parameter int unsigned MAX_SIZE_BIT = 8,
  parameter int unsigned DRAIN_CYCLES = 208340
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_load,
  input  logic                    start_dump,
  input  logic                    cpu_halt,
  output logic                    uart_en,
  output logic                    uart_mode,
  output logic                    uart_ram_id,
  input  logic [MAX_SIZE_BIT-1:0] uart_address,
  input  logic                    uart_on_received,
  input  logic [31:0]             uart_recv_data,
  input  logic                    im_done,
  input  logic                    dm_done,
  output logic                    cpu_rst_n,
  output logic                    im_we,
  output logic [IM_SIZE_BIT-1:0]  im_waddr,
  output logic [31:0]             im_wdata,
  output logic                    dm_we,
  output logic [DM_SIZE_BIT-1:0]  dm_waddr,
  output logic [31:0]             dm_wdata,
  output logic                    dm_sel_uart,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IM = 3'd1,
    LOAD_DM = 3'd2,
    RUN     = 3'd3,
    DUMP    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int unsigned CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        r_state;
  state_t        w_next;
  logic          r_draining;
  logic          w_draining_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_en;
  logic          w_mode;
  logic          w_ram_id;
  logic          w_cpu_rst_n;
  logic          w_sel;

  always_comb begin
    w_next      = r_state;
    // The cycle dm_done first rises counts as drain cycle 0, so DONE lands
    // exactly DRAIN_CYCLES edges after that cycle.
    w_cnt       = r_draining ? r_cnt : '0;

    case (r_state)
      IDLE, DONE: begin
        if (start_load)      w_next = LOAD_IM;
        else if (start_dump) w_next = DUMP;
      end
      LOAD_IM: if (im_done) w_next = LOAD_DM;
      LOAD_DM: if (dm_done) w_next = RUN;
      RUN: begin
        if (start_load)                  w_next = LOAD_IM;
        else if (start_dump || cpu_halt) w_next = DUMP;
      end
      DUMP: begin
        if ((r_draining || dm_done) && (w_cnt == CW'(DRAIN_CYCLES - 1)))
          w_next = DONE;
      end
      default: w_next = IDLE;
    endcase

    // Once started, the drain runs to completion regardless of dm_done.
    w_draining_next = (w_next == DUMP) && (r_draining || ((r_state == DUMP) && dm_done));
    w_cnt_next      = w_draining_next ? (w_cnt + CW'(1)) : '0;

    w_en        = 1'b0;
    w_mode      = 1'b0;
    w_ram_id    = 1'b0;
    w_cpu_rst_n = 1'b0;
    w_sel       = 1'b0;
    case (w_next)
      LOAD_IM: w_en = 1'b1;
      LOAD_DM: begin
        w_en     = 1'b1;
        w_ram_id = 1'b1;
      end
      RUN:     w_cpu_rst_n = 1'b1;
      DUMP: begin
        w_en     = 1'b1;
        w_mode   = 1'b1;
        w_ram_id = 1'b1;
        w_sel    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_draining  <= 1'b0;
      r_cnt       <= '0;
      uart_en     <= 1'b0;
      uart_mode   <= 1'b0;
      uart_ram_id <= 1'b0;
      cpu_rst_n   <= 1'b0;
      dm_sel_uart <= 1'b0;
      im_we       <= 1'b0;
      im_waddr    <= '0;
      im_wdata    <= '0;
      dm_we       <= 1'b0;
      dm_waddr    <= '0;
      dm_wdata    <= '0;
    end else begin
      r_state     <= w_next;
      r_draining  <= w_draining_next;
      r_cnt       <= w_cnt_next;
      uart_en     <= w_en;
      uart_mode   <= w_mode;
      uart_ram_id <= w_ram_id;
      cpu_rst_n   <= w_cpu_rst_n;
      dm_sel_uart <= w_sel;
      // Capture keys off the pre-transition state so the word arriving with
      // im_done/dm_done still lands in the memory being loaded.
      im_we       <= uart_on_received && (r_state == LOAD_IM);
      dm_we       <= uart_on_received && (r_state == LOAD_DM);
      im_waddr    <= IM_SIZE_BIT'(uart_address);
      dm_waddr    <= DM_SIZE_BIT'(uart_address);
      im_wdata    <= uart_recv_data;
      dm_wdata    <= uart_recv_data;
    end
  end

  assign state_o = r_state;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
module tb_uart_boot_ctrl;

  localparam int unsigned DRAIN = 8;

  logic        clk;
  logic        rst_n;
  logic        start_load;
  logic        start_dump;
  logic        cpu_halt;
  logic        uart_en;
  logic        uart_mode;
  logic        uart_ram_id;
  logic [1:0]  uart_address;
  logic        uart_on_received;
  logic [31:0] uart_recv_data;
  logic        im_done;
  logic        dm_done;
  logic        cpu_rst_n;
  logic        im_we;
  logic [1:0]  im_waddr;
  logic [31:0] im_wdata;
  logic        dm_we;
  logic [1:0]  dm_waddr;
  logic [31:0] dm_wdata;
  logic        dm_sel_uart;
  logic [2:0]  state_o;

  uart_boot_ctrl #(
    .IM_SIZE_BIT (2),
    .DM_SIZE_BIT (2),
    .MAX_SIZE_BIT(2),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_load      (start_load),
    .start_dump      (start_dump),
    .cpu_halt        (cpu_halt),
    .uart_en         (uart_en),
    .uart_mode       (uart_mode),
    .uart_ram_id     (uart_ram_id),
    .uart_address    (uart_address),
    .uart_on_received(uart_on_received),
    .uart_recv_data  (uart_recv_data),
    .im_done         (im_done),
    .dm_done         (dm_done),
    .cpu_rst_n       (cpu_rst_n),
    .im_we           (im_we),
    .im_waddr        (im_waddr),
    .im_wdata        (im_wdata),
    .dm_we           (dm_we),
    .dm_waddr        (dm_waddr),
    .dm_wdata        (dm_wdata),
    .dm_sel_uart     (dm_sel_uart),
    .state_o         (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: state number plus per-state expected output tables.
  int          m_state     = 0;
  bit          m_draining  = 0;
  int          m_done_edge = 0;
  bit          e_im_we     = 0;
  bit          e_dm_we     = 0;
  logic [1:0]  e_waddr     = '0;
  logic [31:0] e_wdata     = '0;
  //                           IDLE LIM LDM RUN DUMP DONE
  int tab_en   [6] = '{0, 1, 1, 0, 1, 0};
  int tab_mode [6] = '{0, 0, 0, 0, 1, 0};
  int tab_ram  [6] = '{0, 0, 1, 0, 1, 0};
  int tab_crst [6] = '{0, 0, 0, 1, 0, 0};
  int tab_sel  [6] = '{0, 0, 0, 0, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},     32'(state_o),     32'(m_state));
    chk({tag, ".uart_en"},   32'(uart_en),     32'(tab_en[m_state]));
    chk({tag, ".mode"},      32'(uart_mode),   32'(tab_mode[m_state]));
    chk({tag, ".ram_id"},    32'(uart_ram_id), 32'(tab_ram[m_state]));
    chk({tag, ".cpu_rst_n"}, 32'(cpu_rst_n),   32'(tab_crst[m_state]));
    chk({tag, ".sel_uart"},  32'(dm_sel_uart), 32'(tab_sel[m_state]));
    chk({tag, ".im_we"},     32'(im_we),       32'(e_im_we));
    chk({tag, ".dm_we"},     32'(dm_we),       32'(e_dm_we));
    if (e_im_we) begin
      chk({tag, ".im_waddr"}, 32'(im_waddr), 32'(e_waddr));
      chk({tag, ".im_wdata"}, im_wdata, e_wdata);
    end
    if (e_dm_we) begin
      chk({tag, ".dm_waddr"}, 32'(dm_waddr), 32'(e_waddr));
      chk({tag, ".dm_wdata"}, dm_wdata, e_wdata);
    end
  endtask

  // Apply one cycle of inputs, predict, advance one edge, compare.
  task automatic step(input string tag, input bit sl, input bit sd, input bit h,
                      input bit rx, input logic [1:0] a, input logic [31:0] d,
                      input bit imd, input bit dmd);
    int ns;
    start_load       = sl;
    start_dump       = sd;
    cpu_halt         = h;
    uart_on_received = rx;
    uart_address     = a;
    uart_recv_data   = d;
    im_done          = imd;
    dm_done          = dmd;
    ns = m_state;
    if (!rst_n) begin
      ns = 0;
      m_draining = 0;
      e_im_we = 0;
      e_dm_we = 0;
    end else begin
      e_im_we = rx && (m_state == 1);
      e_dm_we = rx && (m_state == 2);
      e_waddr = a;
      e_wdata = d;
      case (m_state)
        0, 5: if (sl) ns = 1; else if (sd) ns = 4;
        1:    if (imd) ns = 2;
        2:    if (dmd) ns = 3;
        3:    if (sl) ns = 1; else if (sd || h) ns = 4;
        4: begin
          if (!m_draining && dmd) begin
            m_draining  = 1;
            m_done_edge = cyc + DRAIN;
          end
          if (m_draining && (cyc + 1 == m_done_edge)) ns = 5;
        end
        default: ns = 0;
      endcase
      if (ns != 4) m_draining = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    m_state = ns;
    check_all(tag);
  endtask

  task automatic idle_steps(input string tag, input int n, input bit rx);
    for (int i = 0; i < n; i++)
      step(tag, 0, 0, 0, rx, 2'($urandom), $urandom, 0, 0);
  endtask

  // UART stub: four words with random gaps, final strobe coincident with done.
  task automatic load_mem(input string tag, input bit is_dm, input logic [31:0] base,
                          input bit rnd, input int nwords);
    logic [31:0] w;
    for (int k = 0; k < nwords; k++) begin
      idle_steps({tag, ".gap"}, $urandom_range(0, 2), 0);
      w = rnd ? $urandom : (base + 32'(k));
      step(tag, 0, 0, 0, 1, 2'(k), w, !is_dm && (k == 3), is_dm && (k == 3));
    end
  endtask

  int t_first;
  int guard;

  initial begin
    rst_n = 0;
    start_load = 0; start_dump = 0; cpu_halt = 0;
    uart_on_received = 0; uart_address = '0; uart_recv_data = '0;
    im_done = 0; dm_done = 0;
    #1;
    check_all("reset");
    chk("reset.im_waddr", 32'(im_waddr), 0);
    chk("reset.dm_wdata", dm_wdata, 0);
    idle_steps("reset_hold", 2, 1);
    rst_n = 1;

    // Strobes outside load states are ignored.
    idle_steps("idle_strobe", 3, 1);

    // Full load with the plan's word pattern.
    step("start_load", 1, 0, 0, 0, 0, 0, 0, 0);
    load_mem("load_im", 0, 32'h1000_0000, 0, 4);
    load_mem("load_dm", 1, 32'h2000_0000, 0, 4);
    idle_steps("run_strobe", 3, 1);

    // Halt-triggered dump with start_load arriving mid-drain.
    step("halt", 0, 0, 1, 0, 0, 0, 0, 0);
    step("dump_wait", 0, 0, 1, 0, 0, 0, 0, 0);
    idle_steps("dump_wait", $urandom_range(0, 3), 1);
    t_first = cyc;
    step("drain", 0, 0, 0, 0, 0, 0, 0, 1);
    step("drain", 0, 0, 0, 0, 0, 0, 0, 1);
    step("drain", 0, 0, 0, 0, 0, 0, 0, 1);
    step("drain_sl", 1, 0, 0, 0, 0, 0, 0, 0);
    guard = 0;
    while (state_o != 3'd5 && guard < 20) begin
      step("drain", 0, 0, 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("drain_len", 32'(cyc - t_first), DRAIN);
    idle_steps("done_strobe", 3, 1);

    // start_load beats start_dump in DONE; random reload, reset mid-DM strobe.
    step("done_both", 1, 1, 0, 0, 0, 0, 0, 0);
    load_mem("reload_im", 0, 0, 1, 4);
    load_mem("reload_dm", 1, 0, 1, 2);
    uart_on_received = 1;
    uart_address     = 2'd2;
    uart_recv_data   = $urandom;
    #2;
    rst_n = 0;
    #1;
    m_state = 0; m_draining = 0; e_im_we = 0; e_dm_we = 0;
    check_all("async_rst");
    chk("async_rst.dm_waddr", 32'(dm_waddr), 0);
    chk("async_rst.im_wdata", im_wdata, 0);
    step("rst_held", 0, 0, 0, 1, 2'd2, $urandom, 0, 0);
    rst_n = 1;
    idle_steps("post_rst", 4, 1);
    step("post_rst_halt", 0, 0, 1, 1, 0, $urandom, 0, 0);

    // Direct dump from IDLE with immediate dm_done, then a load from RUN.
    step("idle_dump", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DRAIN + 1; i++)
      step("idle_drain", 0, 0, 0, 0, 0, 0, 0, (i < 2));
    step("done_dump", 0, 1, 0, 0, 0, 0, 0, 0);
    step("done_dump_dm", 0, 0, 0, 0, 0, 0, 0, 1);
    idle_steps("done_dump_drain", DRAIN, 0);
    step("start_load2", 1, 0, 0, 0, 0, 0, 0, 0);
    load_mem("load2_im", 0, 0, 1, 4);
    load_mem("load2_dm", 1, 0, 1, 4);
    step("run_sl_halt", 1, 1, 1, 0, 0, 0, 0, 0);
    idle_steps("tail", 2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_boot_ctrl.md
# uart_boot_ctrl

Top-level sequencer between the UART bootloader/dumper and the pipeline CPU's instruction and data memories. It drives the UART controller's `en`/`mode`/`ram_id` inputs and holds the CPU in reset while instruction memory, then data memory, are loaded. It converts the UART's received-word strobes into registered IM/DM write ports, releases the CPU, and on halt or request runs a DM dump over UART with a drain interval. It is the direct downstream consumer of the UART controller's `address`, `on_received`, `recv_data`, `IM_Done` and `DM_Done`.

## Interface
Parameters:
- IM_SIZE_BIT, 8, IM address width in words
- DM_SIZE_BIT, 8, DM address width in words
- MAX_SIZE_BIT, 8, UART address width; must be >= IM_SIZE_BIT and >= DM_SIZE_BIT
- DRAIN_CYCLES, 208340, clocks waited after `dm_done` in DUMP before entering DONE (two UART byte times at 100 MHz / 9600)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_load  in  1  one-cycle synchronous pulse (already debounced); begin IM+DM load
- start_dump  in  1  one-cycle synchronous pulse; begin DM dump
- cpu_halt  in  1  level; CPU has finished
- uart_en  out  1  to UART `en`
- uart_mode  out  1  to UART `mode`; 0 = receive, 1 = send
- uart_ram_id  out  1  to UART `ram_id`; 0 = IM, 1 = DM
- uart_address  in  MAX_SIZE_BIT  from UART `address`
- uart_on_received  in  1  from UART `on_received`
- uart_recv_data  in  32  from UART `recv_data`
- im_done  in  1  from UART `IM_Done`
- dm_done  in  1  from UART `DM_Done`
- cpu_rst_n  out  1  active-low CPU reset
- im_we  out  1  IM write enable
- im_waddr  out  IM_SIZE_BIT  IM write address
- im_wdata  out  32  IM write data
- dm_we  out  1  DM write enable
- dm_waddr  out  DM_SIZE_BIT  DM write address
- dm_wdata  out  32  DM write data
- dm_sel_uart  out  1  1 = DM read port is driven by `uart_address` (external mux)
- state_o  out  3  current state encoding, used for LEDs

## Operation
- States and encodings: IDLE=0, LOAD_IM=1, LOAD_DM=2, RUN=3, DUMP=4, DONE=5. Encodings 6 and 7 are unreachable and return to IDLE.
- Outputs are registered and decoded from the next state, so they change on the same edge as `state_o`.
- IDLE: uart_en=0, cpu_rst_n=0. `start_load` -> LOAD_IM; `start_dump` -> DUMP.
- LOAD_IM: uart_en=1, uart_mode=0, uart_ram_id=0, cpu_rst_n=0. `im_done` -> LOAD_DM. uart_en stays 1 across this transition so the UART keeps IM_Done set.
- LOAD_DM: uart_en=1, uart_mode=0, uart_ram_id=1, cpu_rst_n=0. `dm_done` -> RUN.
- RUN: uart_en=0, cpu_rst_n=1. `cpu_halt` or `start_dump` -> DUMP; `start_load` -> LOAD_IM.
- DUMP: uart_en=1, uart_mode=1, cpu_rst_n=0, dm_sel_uart=1.
  - On the first cycle `dm_done`=1, the drain counter loads 0 and counts up.
  - When count reaches DRAIN_CYCLES-1 -> DONE.
  - `dm_done` falling during drain does not restart the count.
- DONE: uart_en=0, cpu_rst_n=0, dm_sel_uart=0. `start_load` -> LOAD_IM; `start_dump` -> DUMP.
- `uart_mode` and `uart_ram_id` change only on edges where uart_en is 0 before or after, except the LOAD_IM->LOAD_DM ram_id change.
- Write capture, registered:
  - im_we <= uart_on_received && state==LOAD_IM; dm_we <= uart_on_received && state==LOAD_DM.
  - addr <= uart_address truncated to IM_SIZE_BIT/DM_SIZE_BIT; data <= uart_recv_data.
  - Capture uses the pre-transition state, so the final word (strobe in the same cycle as im_done/dm_done) is written to the correct memory.
- `uart_on_received` in any other state: ignored; we stays 0.
- Simultaneous pulses: `start_load` beats `start_dump`, which beats `cpu_halt`. `start_load` is ignored in LOAD_IM, LOAD_DM and DUMP.

## Timing
- Reset values (asynchronous, all outputs): state IDLE, uart_en 0, uart_mode 0, uart_ram_id 0, cpu_rst_n 0, im_we/dm_we 0, addresses/data 0, dm_sel_uart 0, drain count 0.
- Reset asserted mid-operation: immediate return to the above; uart_en=0 also clears the UART.
- `start_load` in cycle N: state/uart_en update at edge N+1.
- `uart_on_received` high in cycle N: write pulse high exactly in cycle N+1, one cycle wide.
- `im_done` high in cycle N: ram_id=1 at edge N+1.
- `dm_done` high in cycle N in LOAD_DM: cpu_rst_n=1 and uart_en=0 at edge N+1.
- `dm_done` first high in cycle N in DUMP: DONE at edge N+DRAIN_CYCLES.

## Test plan
Use a behavioural UART stub, IM_SIZE_BIT=DM_SIZE_BIT=MAX_SIZE_BIT=2, DRAIN_CYCLES=8.
- Full load: pulse start_load; stub sends 4 IM words 0x1000_000k then 4 DM words 0x2000_000k, with the final strobe coincident with done -> im writes at addr 0..3 and dm writes at addr 0..3, each one cycle after its strobe; RUN reached with cpu_rst_n=1, uart_en=0.
- Strobe in IDLE, RUN and DONE -> no im_we/dm_we.
- Halt dump: from RUN raise cpu_halt -> next edge DUMP with mode=1, en=1, dm_sel_uart=1, cpu_rst_n=0; dm_done high at cycle T -> state DONE at T+8, uart_en 0.
- Simultaneous start_load and start_dump in DONE -> LOAD_IM, ram_id 0, mode 0.
- rst_n low mid-LOAD_DM, including during a strobe -> all outputs at reset values asynchronously, no write pulse after release; IDLE held until start_load.
- start_load during DUMP drain -> ignored; DONE still reached at T+8.
